// File: rtl/left_shift_sequential_if.sv
// Handshake and data bundle for the multi-cycle left shifter.
// The master issues start/in/shift and observes the result; the slave is the shifter itself.
`timescale 1ns/1ps
interface left_shift_sequential_if #(
  parameter int WIDTH = 16,
  parameter int SHW   = 4
);
  // start is a request sampled on rising clk; it is taken only when the shifter
  // is idle or in its done cycle, and done is the one-cycle "result valid" reply.
  logic             start;
  logic [WIDTH-1:0] in;
  logic [SHW-1:0]   shift;
  logic [WIDTH-1:0] out;
  logic             cout;
  logic             busy;
  logic             done;

  modport master (
    output start, in, shift,
    input  out, cout, busy, done
  );

  modport slave (
    input  start, in, shift,
    output out, cout, busy, done
  );
endinterface

// File: rtl/left_shift_sequential.sv
// Multi-cycle logical left shifter: one bit position per clock, zero fill,
// last bit out of the MSB reported on cout, start/done handshake.
`timescale 1ns/1ps
module left_shift_sequential #(
  parameter int WIDTH = 16,
  parameter int SHW   = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  left_shift_sequential_if.slave bus,
  output logic [1:0]          dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t         state;
  logic [SHW-1:0] cnt;

  assign dbg_state = state;

  // busy/done are registered alongside state so they never see start combinationally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      bus.out  <= '0;
      bus.cout <= 1'b0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            bus.out  <= bus.in;
            cnt      <= bus.shift;
            bus.cout <= 1'b0;
            if (bus.shift == '0) begin
              state    <= DONE;
              bus.busy <= 1'b0;
              bus.done <= 1'b1;
            end else begin
              state    <= SHIFT;
              bus.busy <= 1'b1;
              bus.done <= 1'b0;
            end
          end else begin
            state    <= IDLE;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
          end
        end
        SHIFT: begin
          bus.cout <= bus.out[WIDTH-1];
          bus.out  <= {bus.out[WIDTH-2:0], 1'b0};
          cnt      <= cnt - SHW'(1);
          if (cnt == SHW'(1)) begin
            state    <= DONE;
            bus.busy <= 1'b0;
            bus.done <= 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
          bus.done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_left_shift_sequential.sv
// Self-checking bench for left_shift_sequential: directed literal cases plus
// randomized traffic compared every cycle against a behavioural model.
`timescale 1ns/1ps
module tb_left_shift_sequential;

  logic       clk;
  logic       rst_n;
  logic [1:0] dbg_state;

  left_shift_sequential_if #(.WIDTH(16), .SHW(4)) bus ();

  left_shift_sequential #(.WIDTH(16), .SHW(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard counters ----------------
  int total = 0;
  int bad   = 0;
  logic [15:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Tracks an operation as "cycles of shifting left"; the result is computed
  // up front with plain arithmetic at acceptance.
  bit          m_inflight = 0;
  int          m_rem      = 0;
  logic [15:0] m_out      = '0;
  logic        m_cout     = 1'b0;
  int          m_accepts  = 0;
  bit          cmp_en     = 0;

  function automatic logic [15:0] ref_out(input logic [15:0] a, input int s);
    int unsigned v;
    v = (int'(a) << s) & 32'hFFFF;
    return v[15:0];
  endfunction

  function automatic logic ref_cout(input logic [15:0] a, input int s);
    int unsigned v;
    if (s == 0) return 1'b0;
    v = (int'(a) >> (16 - s)) & 1;
    return v[0];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_inflight = 0;
      m_rem      = 0;
      m_out      = '0;
      m_cout     = 1'b0;
    end else if (m_inflight && m_rem > 0) begin
      m_rem = m_rem - 1;
    end else if (bus.start === 1'b1) begin
      m_out      = ref_out(bus.in, int'(bus.shift));
      m_cout     = ref_cout(bus.in, int'(bus.shift));
      m_rem      = int'(bus.shift);
      m_inflight = 1;
      m_accepts++;
      exp_q.push_back(m_out);
    end else begin
      m_inflight = 0;
    end
  end

  // Compare process: outputs checked every cycle once reset has been applied.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("busy", {31'd0, bus.busy}, {31'd0, (m_inflight && m_rem > 0)});
      chk("done", {31'd0, bus.done}, {31'd0, (m_inflight && m_rem == 0)});
      if (!(m_inflight && m_rem > 0)) begin
        chk("out",  {16'd0, bus.out},  {16'd0, m_out});
        chk("cout", {31'd0, bus.cout}, {31'd0, m_cout});
      end
      if (bus.done === 1'b1 && exp_q.size() > 0) begin
        chk("done_result", {16'd0, bus.out}, {16'd0, exp_q.pop_front()});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.start = 1'b0;
      bus.in    = 16'($urandom);
      bus.shift = 4'($urandom);
    end
  endtask

  // Issue one op at the next negedge and wait for done; checks against literals.
  task automatic do_op(input string nm, input logic [15:0] a, input logic [3:0] s,
                       input logic [15:0] eo, input logic ec, input int el);
    int lat;
    @(negedge clk);
    bus.start = 1'b1;
    bus.in    = a;
    bus.shift = s;
    @(negedge clk);
    bus.start = 1'b0;
    bus.in    = 16'($urandom);
    bus.shift = 4'($urandom);
    lat = 1;
    chk({nm, "_busy_c1"}, {31'd0, bus.busy}, {31'd0, (s != 4'd0)});
    while (bus.done !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk({nm, "_latency"}, lat, el);
    chk({nm, "_out"},  {16'd0, bus.out},  {16'd0, eo});
    chk({nm, "_cout"}, {31'd0, bus.cout}, {31'd0, ec});
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int lat;
    int base;
    int cyc;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.in    = '0;
    bus.shift = '0;
    repeat (3) @(negedge clk);
    chk("reset_out",  {16'd0, bus.out},  32'd0);
    chk("reset_cout", {31'd0, bus.cout}, 32'd0);
    chk("reset_busy", {31'd0, bus.busy}, 32'd0);
    chk("reset_done", {31'd0, bus.done}, 32'd0);
    rst_n  = 1'b1;
    cmp_en = 1;
    idle_cycles(2);

    do_op("zero_shift", 16'hA5C3, 4'd0,  16'hA5C3, 1'b0, 1);
    idle_cycles(1);
    do_op("single",     16'h8001, 4'd1,  16'h0002, 1'b1, 2);
    idle_cycles(1);
    do_op("max_shift",  16'h0003, 4'd15, 16'h8000, 1'b1, 16);
    idle_cycles(2);

    // Start held through SHIFT with operands changing underneath.
    @(negedge clk);
    bus.start = 1'b1; bus.in = 16'h1234; bus.shift = 4'd4;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      bus.start = (c < 4);
      bus.in    = 16'($urandom);
      bus.shift = 4'($urandom);
    end
    @(negedge clk);
    bus.start = 1'b0;
    chk("midstart_done", {31'd0, bus.done}, 32'd1);
    chk("midstart_out",  {16'd0, bus.out},  32'h2340);
    chk("midstart_cout", {31'd0, bus.cout}, 32'd1);
    idle_cycles(2);

    // Back-to-back: new start presented during the done cycle.
    do_op("b2b_first", 16'h00F0, 4'd2, 16'h03C0, 1'b0, 3);
    bus.start = 1'b1; bus.in = 16'h00FF; bus.shift = 4'd8;
    @(negedge clk);
    bus.start = 1'b0;
    lat = 1;
    chk("b2b_no_bubble", {31'd0, bus.busy}, 32'd1);
    while (bus.done !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("b2b_latency", lat, 9);
    chk("b2b_out",  {16'd0, bus.out},  32'hFF00);
    chk("b2b_cout", {31'd0, bus.cout}, 32'd0);
    idle_cycles(2);

    // Reset in the middle of a shift: immediate clear, no done afterwards.
    @(negedge clk);
    bus.start = 1'b1; bus.in = 16'hFFFF; bus.shift = 4'd9;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset_out",  {16'd0, bus.out},  32'd0);
    chk("midreset_cout", {31'd0, bus.cout}, 32'd0);
    chk("midreset_busy", {31'd0, bus.busy}, 32'd0);
    chk("midreset_done", {31'd0, bus.done}, 32'd0);
    exp_q.delete();
    #1 rst_n = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      chk("no_done_after_reset", {31'd0, bus.done}, 32'd0);
    end

    // Randomized traffic, checked by the compare process.
    base = m_accepts;
    cyc  = 0;
    while ((m_accepts - base) < 1000 && cyc < 40000) begin
      @(negedge clk);
      bus.start = ($urandom_range(0, 3) != 0);
      bus.in    = 16'($urandom);
      bus.shift = 4'($urandom_range(0, 15));
      cyc++;
    end
    chk("random_ops_completed", {31'd0, ((m_accepts - base) >= 1000)}, 32'd1);
    idle_cycles(20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
